// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - handshake/bus bundle between ID/EX, the ALU stage and MEM
// Signals:
//   in_valid/in_ready/alu_control/op_a/op_b/in_tag : upstream operation offer
//   flush                                          : squash held result
//   out_valid/out_ready/result/zero/overflow/illegal/out_tag : EX/MEM slot
// Modports: slave = ALU stage view, master = surrounding pipeline/bench view.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, alu_control, op_a, op_b, in_tag, flush, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal, out_tag
  );

  modport master (
    output in_valid, alu_control, op_a, op_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal, out_tag
  );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage ALU with a one-entry EX/MEM result register
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : alu_exec_stage_if.slave (operation in, flush, registered result out)
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           rst,
  alu_exec_stage_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             overflow_q,  overflow_d;
  logic             illegal_q,   illegal_d;
  logic [TAG_W-1:0] tag_q,       tag_d;

  logic             in_ready;
  logic             load;

  always_comb begin
    sum     = bus.op_a + bus.op_b;
    diff    = bus.op_a - bus.op_b;
    add_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
    sub_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (diff[WIDTH-1] != bus.op_a[WIDTH-1]);

    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_control)
      OP_AND: alu_res = bus.op_a & bus.op_b;
      OP_OR:  alu_res = bus.op_a | bus.op_b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      // Sign of A-B is wrong exactly when the subtraction overflows.
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      OP_NOR: alu_res = ~(bus.op_a | bus.op_b);
      OP_XOR: alu_res = bus.op_a ^ bus.op_b;
      default: alu_ill = 1'b1;
    endcase
  end

  // Slot can take a new op when empty or when its current result leaves this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign load     = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    tag_d       = tag_q;
    if (bus.flush) begin
      // Squash wins over a same-cycle load; the offered op is dropped.
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      overflow_d  = alu_ovf;
      illegal_d   = alu_ill;
      tag_d       = bus.in_tag;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage
module tb_alu_exec_stage;
  localparam int W = 32;
  localparam int T = 5;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_XOR = 4'b1101;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ovf;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_stage_if #(.WIDTH(W), .TAG_W(T)) bus ();
  alu_exec_stage #(.WIDTH(W), .TAG_W(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  logic [4:0] tag_ctr = 5'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: plain signed arithmetic, overflow = true result does not fit in 32 bits.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] t);
    exp_t e;
    longint sa;
    longint sbv;
    longint ex;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    e.res = 32'd0; e.ovf = 1'b0; e.ill = 1'b0; e.tag = t;
    case (c)
      C_AND: e.res = a & b;
      C_OR:  e.res = a | b;
      C_ADD: begin
        ex = sa + sbv;
        e.res = ex[31:0];
        e.ovf = (ex != longint'($signed(ex[31:0])));
      end
      C_SUB: begin
        ex = sa - sbv;
        e.res = ex[31:0];
        e.ovf = (ex != longint'($signed(ex[31:0])));
      end
      C_SLT: e.res = (sa < sbv) ? 32'd1 : 32'd0;
      C_NOR: e.res = ~(a | b);
      C_XOR: e.res = a ^ b;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got result %h tag %h want no output", bus.result, bus.out_tag);
      end else begin
        mon_e = sb.pop_front();
        check("out_result",   bus.result,   mon_e.res);
        check("out_zero",     bus.zero,     mon_e.z);
        check("out_overflow", bus.overflow, mon_e.ovf);
        check("out_illegal",  bus.illegal,  mon_e.ill);
        check("out_tag",      bus.out_tag,  mon_e.tag);
      end
    end
  end

  // Offer one op; push its expectation at the edge where it is accepted. Returns at posedge+1.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input exp_t e, input bit rnd);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1; bus.alu_control = c; bus.op_a = a; bus.op_b = b; bus.in_tag = e.tag;
    for (int i = 0; i < 64; i++) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        sb.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready low for 64 cycles want accept");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic dsend(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic z, input logic ovf, input logic ill);
    exp_t e;
    e.res = res; e.z = z; e.ovf = ovf; e.ill = ill; e.tag = tag_ctr;
    tag_ctr = tag_ctr + 5'd1;
    send(c, a, b, e, 1'b0);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || bus.out_valid === 1'b1); i++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_empty", sb.size(), 0);
    check("drain_out_valid", bus.out_valid, 0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [3:0] c;
    logic [31:0] a;
    logic [31:0] b;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.alu_control = 4'd0; bus.op_a = 32'd0; bus.op_b = 32'd0;
    bus.in_tag = 5'd0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result",    bus.result,    0);
    check("rst_zero",      bus.zero,      0);
    check("rst_overflow",  bus.overflow,  0);
    check("rst_illegal",   bus.illegal,   0);
    check("rst_out_tag",   bus.out_tag,   0);
    check("rst_in_ready",  bus.in_ready,  1);
    @(posedge clk); #1;

    // First op with single-cycle latency check.
    bus.out_ready = 1'b1;
    tag_ctr = 5'd9;
    dsend(C_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;

    dsend(C_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    dsend(C_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    dsend(C_SLT, 32'd1, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0);
    dsend(C_SUB, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0);
    dsend(C_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dsend(C_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    dsend(C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    dsend(C_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    dsend(C_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
    dsend(C_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    dsend(C_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
    dsend(4'b0011, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1'b0, 1'b1);
    drain();

    // Backpressure: hold first result two cycles, then three results in order.
    dsend(C_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.alu_control = C_OR; bus.op_a = 32'h1; bus.op_b = 32'h2;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_in_ready",  bus.in_ready,  0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_result",    bus.result,    32'd30);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    dsend(C_OR, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0);
    dsend(C_SUB, 32'd2, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0);
    drain();

    // Flush of an op offered in the same cycle: it must never appear.
    bus.in_valid = 1'b1; bus.alu_control = C_ADD; bus.op_a = 32'd1; bus.op_b = 32'd1;
    bus.in_tag = 5'd31; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;

    // Flush of a held result under backpressure.
    bus.out_ready = 1'b0;
    dsend(C_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("flush_held_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    drain();

    // Reset while a result is held with out_ready low.
    bus.out_ready = 1'b0;
    dsend(C_ADD, 32'h0000_0100, 32'h0000_0011, 32'h0000_0111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_result",    bus.result,    0);
    check("midrst_zero",      bus.zero,      0);
    check("midrst_overflow",  bus.overflow,  0);
    check("midrst_illegal",   bus.illegal,   0);
    check("midrst_out_tag",   bus.out_tag,   0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and idle gaps.
    for (int n = 0; n < 400; n++) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      c = 4'($urandom_range(0, 15));
      a = rand_op();
      b = rand_op();
      e = model(c, a, b, 5'($urandom_range(0, 31)));
      send(c, a, b, e, 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
